// File: rtl/muldiv_pkg.sv
// ============================================================================
//  muldiv_pkg
//  Shared types for the EX-stage iterative multiply/divide unit.
//  Rev 1.0
// ============================================================================
`default_nettype none

package muldiv_pkg;

    localparam int c_XLEN_MAX = 64;

    // Encoded to match the RV32M/RV64M funct3 field
    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mdop_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdst_t;

    typedef struct packed {
        logic                  is_md;
        mdop_t                 mdop;
        logic [c_XLEN_MAX-1:0] opr_a;
        logic [c_XLEN_MAX-1:0] opr_b;
        logic [4:0]            rd;
    } ex_muldiv_in_t;

    typedef struct packed {
        logic                  busy;
        logic                  valid;
        logic [4:0]            rd;
        logic [c_XLEN_MAX-1:0] res;
    } ex_muldiv_out_t;

    function automatic logic op_is_div(input mdop_t op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    function automatic logic op_a_signed(input mdop_t op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_b_signed(input mdop_t op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_sign_fixup.sv
// ============================================================================
//  muldiv_sign_fixup
//  Operand magnitude extraction and final result negation for mul and div.
//  Rev 1.0
// ============================================================================
`default_nettype none

module muldiv_sign_fixup #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]   i_opr_a,
    input  logic [XLEN-1:0]   i_opr_b,
    input  logic              i_a_signed,
    input  logic              i_b_signed,
    output logic [XLEN-1:0]   o_a_mag,
    output logic [XLEN-1:0]   o_b_mag,
    output logic              o_a_neg,
    output logic              o_b_neg,
    input  logic [2*XLEN-1:0] i_raw_res,
    input  logic              i_res_neg,
    output logic [2*XLEN-1:0] o_fix_res
);

    // The magnitude of the most negative value is exact as an unsigned XLEN value
    always_comb begin
        o_a_neg   = i_a_signed & i_opr_a[XLEN-1];
        o_b_neg   = i_b_signed & i_opr_b[XLEN-1];
        o_a_mag   = o_a_neg ? -i_opr_a : i_opr_a;
        o_b_mag   = o_b_neg ? -i_opr_b : i_opr_b;
        o_fix_res = i_res_neg ? -i_raw_res : i_raw_res;
    end

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
//  ex_muldiv_unit
//  Bit-serial RV32M/RV64M multiply/divide unit sitting beside the EX-stage ALU.
//  Rev 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  mdop_t           mdop,
    input  logic [XLEN-1:0] opr_a,
    input  logic [XLEN-1:0] opr_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            out_valid,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] res
);

    localparam int              CNT_W      = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0] c_MIN      = {1'b1, {(XLEN-1){1'b0}}};

    mdst_t             r_state_q,    w_state_d;
    mdop_t             r_op_q,       w_op_d;
    logic [4:0]        r_rd_q,       w_rd_d;
    logic [XLEN-1:0]   r_b_q,        w_b_d;
    logic              r_sa_q,       w_sa_d;
    logic              r_sb_q,       w_sb_d;
    logic [CNT_W-1:0]  r_cnt_q,      w_cnt_d;
    logic [2*XLEN-1:0] r_prod_q,     w_prod_d;
    logic [XLEN-1:0]   r_rem_q,      w_rem_d;
    logic              r_spec_q,     w_spec_d;
    logic [XLEN-1:0]   r_spec_res_q, w_spec_res_d;
    logic [XLEN-1:0]   r_res_q,      w_res_d;
    logic [4:0]        r_rd_out_q,   w_rd_out_d;

    logic [XLEN-1:0]   w_a_mag, w_b_mag;
    logic              w_a_neg, w_b_neg;
    logic              w_div0, w_ovf;
    logic [XLEN-1:0]   w_spec_val;
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_div_shift;
    logic              w_div_ge;
    logic [XLEN-1:0]   w_div_sub;
    logic [2*XLEN-1:0] w_raw, w_fix;
    logic              w_neg;
    logic [XLEN-1:0]   w_res_done;

    muldiv_sign_fixup #(.XLEN(XLEN)) u_sign_fixup (
        .i_opr_a    (opr_a),
        .i_opr_b    (opr_b),
        .i_a_signed (op_a_signed(mdop)),
        .i_b_signed (op_b_signed(mdop)),
        .o_a_mag    (w_a_mag),
        .o_b_mag    (w_b_mag),
        .o_a_neg    (w_a_neg),
        .o_b_neg    (w_b_neg),
        .i_raw_res  (w_raw),
        .i_res_neg  (w_neg),
        .o_fix_res  (w_fix)
    );

    always_comb begin
        w_div0     = op_is_div(mdop) && (opr_b == '0);
        w_ovf      = ((mdop == MD_DIV) || (mdop == MD_REM)) && (opr_a == c_MIN) && (opr_b == '1);
        w_spec_val = '0;
        if (w_div0) begin
            w_spec_val = ((mdop == MD_DIV) || (mdop == MD_DIVU)) ? '1 : opr_a;
        end else if (w_ovf) begin
            w_spec_val = (mdop == MD_DIV) ? c_MIN : '0;
        end
    end

    // The XLEN+1-bit partial remainder exists only as the shifted trial value;
    // the stored remainder is always below the divisor and fits XLEN bits.
    assign w_mul_sum   = {1'b0, r_prod_q[2*XLEN-1:XLEN]} + {1'b0, r_b_q};
    assign w_div_shift = {r_rem_q, r_prod_q[XLEN-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_b_q});
    assign w_div_sub   = w_div_shift[XLEN-1:0] - r_b_q;

    always_comb begin
        w_raw = r_prod_q;
        w_neg = r_sa_q ^ r_sb_q;
        case (r_op_q)
            MD_DIV, MD_DIVU: w_raw = {{XLEN{1'b0}}, r_prod_q[XLEN-1:0]};
            MD_REM, MD_REMU: begin
                w_raw = {{XLEN{1'b0}}, r_rem_q};
                w_neg = r_sa_q;
            end
            default: ;
        endcase
        w_res_done = w_fix[XLEN-1:0];
        if (r_spec_q) begin
            w_res_done = r_spec_res_q;
        end else if ((r_op_q == MD_MULH) || (r_op_q == MD_MULHSU) || (r_op_q == MD_MULHU)) begin
            w_res_done = w_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        if (flush) begin
            w_state_d = ST_IDLE;
        end else begin
            case (r_state_q)
                ST_IDLE: if (in_valid) w_state_d = (w_div0 || w_ovf) ? ST_DONE : ST_CALC;
                ST_CALC: if (r_cnt_q == c_CNT_LAST) w_state_d = ST_DONE;
                ST_DONE: w_state_d = ST_IDLE;
                default: w_state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (r_state_q == ST_IDLE);
        busy      = ~in_ready;
        out_valid = (r_state_q == ST_DONE) && !flush;
        res       = (r_state_q == ST_DONE) ? w_res_done : r_res_q;
        rd_out    = (r_state_q == ST_DONE) ? r_rd_q : r_rd_out_q;
    end

    always_comb begin
        w_op_d       = r_op_q;
        w_rd_d       = r_rd_q;
        w_b_d        = r_b_q;
        w_sa_d       = r_sa_q;
        w_sb_d       = r_sb_q;
        w_cnt_d      = r_cnt_q;
        w_prod_d     = r_prod_q;
        w_rem_d      = r_rem_q;
        w_spec_d     = r_spec_q;
        w_spec_res_d = r_spec_res_q;
        w_res_d      = r_res_q;
        w_rd_out_d   = r_rd_out_q;
        case (r_state_q)
            ST_IDLE: begin
                if (in_valid && !flush) begin
                    w_op_d       = mdop;
                    w_rd_d       = rd_in;
                    w_b_d        = w_b_mag;
                    w_sa_d       = w_a_neg;
                    w_sb_d       = w_b_neg;
                    w_cnt_d      = '0;
                    w_prod_d     = {{XLEN{1'b0}}, w_a_mag};
                    w_rem_d      = '0;
                    w_spec_d     = w_div0 || w_ovf;
                    w_spec_res_d = w_spec_val;
                end
            end
            ST_CALC: begin
                w_cnt_d = r_cnt_q + 1'b1;
                if (op_is_div(r_op_q)) begin
                    // Low half shifts dividend bits out and quotient bits in
                    w_rem_d  = w_div_ge ? w_div_sub : w_div_shift[XLEN-1:0];
                    w_prod_d = {r_prod_q[2*XLEN-1:XLEN], r_prod_q[XLEN-2:0], w_div_ge};
                end else if (r_prod_q[0]) begin
                    w_prod_d = {w_mul_sum, r_prod_q[XLEN-1:1]};
                end else begin
                    w_prod_d = {1'b0, r_prod_q[2*XLEN-1:1]};
                end
            end
            ST_DONE: begin
                if (!flush) begin
                    w_res_d    = w_res_done;
                    w_rd_out_d = r_rd_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op_q       <= MD_MUL;
            r_rd_q       <= '0;
            r_b_q        <= '0;
            r_sa_q       <= 1'b0;
            r_sb_q       <= 1'b0;
            r_cnt_q      <= '0;
            r_prod_q     <= '0;
            r_rem_q      <= '0;
            r_spec_q     <= 1'b0;
            r_spec_res_q <= '0;
            r_res_q      <= '0;
            r_rd_out_q   <= '0;
        end else begin
            r_op_q       <= w_op_d;
            r_rd_q       <= w_rd_d;
            r_b_q        <= w_b_d;
            r_sa_q       <= w_sa_d;
            r_sb_q       <= w_sb_d;
            r_cnt_q      <= w_cnt_d;
            r_prod_q     <= w_prod_d;
            r_rem_q      <= w_rem_d;
            r_spec_q     <= w_spec_d;
            r_spec_res_q <= w_spec_res_d;
            r_res_q      <= w_res_d;
            r_rd_out_q   <= w_rd_out_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
// ============================================================================
//  tb_ex_muldiv_unit
//  Directed vector bench for ex_muldiv_unit at XLEN=32 and XLEN=64.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_ex_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    logic        iv32, ir32, busy32, ov32;
    mdop_t       op32;
    logic [31:0] a32, b32, res32;
    logic [4:0]  rdi32, rdo32;

    logic        iv64, ir64, busy64, ov64;
    mdop_t       op64;
    logic [63:0] a64, b64, res64;
    logic [4:0]  rdi64, rdo64;

    ex_muldiv_unit #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv32), .in_ready(ir32),
        .mdop(op32), .opr_a(a32), .opr_b(b32), .rd_in(rdi32), .busy(busy32),
        .out_valid(ov32), .rd_out(rdo32), .res(res32)
    );

    ex_muldiv_unit #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(iv64), .in_ready(ir64),
        .mdop(op64), .opr_a(a64), .opr_b(b64), .rd_in(rdi64), .busy(busy64),
        .out_valid(ov64), .rd_out(rdo64), .res(res64)
    );

    bit          sel64;
    logic        cur_ov, cur_busy, cur_ir;
    logic [63:0] cur_res;
    logic [4:0]  cur_rd;
    assign cur_ov   = sel64 ? ov64   : ov32;
    assign cur_busy = sel64 ? busy64 : busy32;
    assign cur_ir   = sel64 ? ir64   : ir32;
    assign cur_res  = sel64 ? res64  : {32'd0, res32};
    assign cur_rd   = sel64 ? rdo64  : rdo32;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          w64;
        mdop_t       op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    localparam logic [63:0] M32   = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] M64   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MIN32 = 64'h0000_0000_8000_0000;
    localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

    // Issue one op; check latency, busy in between, result, tag and one-cycle strobe
    task automatic run_op(input bit w64, input mdop_t op, input logic [63:0] a, input logic [63:0] b,
                          input logic [4:0] rd, input logic [63:0] exp, input int lat,
                          input bit poke, input string tag);
        int cyc;
        int busy_bad;
        sel64 = w64;
        @(negedge clk);
        if (w64) begin
            iv64 = 1'b1; op64 = op; a64 = a; b64 = b; rdi64 = rd;
        end else begin
            iv32 = 1'b1; op32 = op; a32 = a[31:0]; b32 = b[31:0]; rdi32 = rd;
        end
        @(negedge clk);
        iv32 = 1'b0;
        iv64 = 1'b0;
        cyc = 1;
        busy_bad = 0;
        while (!cur_ov && cyc <= lat + 4) begin
            if (cur_busy !== 1'b1) busy_bad++;
            if (poke && cyc == 5) begin
                a32 = 32'd1; b32 = 32'd1; a64 = 64'd1; b64 = 64'd1;
                rdi32 = ~rd; rdi64 = ~rd;
                iv32 = !w64; iv64 = w64;
            end else begin
                iv32 = 1'b0; iv64 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        iv32 = 1'b0;
        iv64 = 1'b0;
        check({tag, " out_valid"}, 64'(cur_ov), 64'd1);
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " res"}, cur_res, exp);
        check({tag, " rd_out"}, 64'(cur_rd), 64'(rd));
        check({tag, " busy_low_cycles"}, 64'(busy_bad), 64'd0);
        check({tag, " busy_at_done"}, 64'(cur_busy), 64'd1);
        @(negedge clk);
        check({tag, " strobe_one_cycle"}, 64'(cur_ov), 64'd0);
        check({tag, " ready_after"}, 64'(cur_ir), 64'd1);
        check({tag, " res_held"}, cur_res, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit seen;

        vecs[0]  = '{0, MD_MUL,    64'd7,      64'hFFFF_FFFD, 64'hFFFF_FFEB, 33};
        vecs[1]  = '{0, MD_MULHU,  M32,        M32,           64'hFFFF_FFFE, 33};
        vecs[2]  = '{0, MD_MULH,   M32,        M32,           64'h0,         33};
        vecs[3]  = '{0, MD_MULHSU, M32,        M32,           64'hFFFF_FFFF, 33};
        vecs[4]  = '{0, MD_DIV,    64'hFFFF_FFF9, 64'd2,      64'hFFFF_FFFD, 33};
        vecs[5]  = '{0, MD_REM,    64'hFFFF_FFF9, 64'd2,      64'hFFFF_FFFF, 33};
        vecs[6]  = '{0, MD_DIVU,   64'd100,    64'd7,         64'd14,        33};
        vecs[7]  = '{0, MD_REMU,   64'd100,    64'd7,         64'd2,         33};
        vecs[8]  = '{0, MD_DIVU,   64'd5,      64'd0,         64'hFFFF_FFFF, 1};
        vecs[9]  = '{0, MD_REM,    64'd5,      64'd0,         64'd5,         1};
        vecs[10] = '{0, MD_DIV,    MIN32,      M32,           MIN32,         1};
        vecs[11] = '{0, MD_REM,    MIN32,      M32,           64'd0,         1};
        vecs[12] = '{0, MD_MULH,   MIN32,      MIN32,         64'h4000_0000, 33};
        vecs[13] = '{0, MD_REM,    64'd7,      64'hFFFF_FFFE, 64'd1,         33};
        vecs[14] = '{1, MD_MUL,    64'd7,      64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        vecs[15] = '{1, MD_MULHU,  M64,        M64,           64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[16] = '{1, MD_MULH,   M64,        M64,           64'h0,         65};
        vecs[17] = '{1, MD_MULHSU, M64,        M64,           M64,           65};
        vecs[18] = '{1, MD_DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[19] = '{1, MD_REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, M64,      65};
        vecs[20] = '{1, MD_DIVU,   64'd100,    64'd7,         64'd14,        65};
        vecs[21] = '{1, MD_REMU,   64'd100,    64'd7,         64'd2,         65};
        vecs[22] = '{1, MD_DIVU,   64'd5,      64'd0,         M64,           1};
        vecs[23] = '{1, MD_DIV,    MIN64,      M64,           MIN64,         1};

        rst = 1'b1; flush = 1'b0; sel64 = 1'b0;
        iv32 = 1'b0; op32 = MD_MUL; a32 = '0; b32 = '0; rdi32 = '0;
        iv64 = 1'b0; op64 = MD_MUL; a64 = '0; b64 = '0; rdi64 = '0;
        repeat (2) @(negedge clk);
        check("reset in_ready32", 64'(ir32), 64'd1);
        check("reset busy32", 64'(busy32), 64'd0);
        check("reset out_valid32", 64'(ov32), 64'd0);
        check("reset res32", 64'(res32), 64'd0);
        check("reset rd_out32", 64'(rdo32), 64'd0);
        check("reset in_ready64", 64'(ir64), 64'd1);
        check("reset res64", res64, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].w64, vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1),
                   vecs[i].exp, vecs[i].lat, 1'b0, $sformatf("vec%0d", i));
        end

        run_op(1'b0, MD_MUL, 64'd7, 64'hFFFF_FFFD, 5'd9, 64'hFFFF_FFEB, 33, 1'b1, "busy_ignore");

        // Flush in the tenth CALC cycle
        sel64 = 1'b0;
        @(negedge clk);
        iv32 = 1'b1; op32 = MD_DIVU; a32 = 32'd1000; b32 = 32'd7; rdi32 = 5'd3;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        seen = ov32;
        @(negedge clk);
        flush = 1'b0;
        check("flush in_ready", 64'(ir32), 64'd1);
        check("flush busy", 64'(busy32), 64'd0);
        repeat (40) begin
            if (ov32) seen = 1'b1;
            @(negedge clk);
        end
        check("flush no_out_valid", 64'(seen), 64'd0);
        run_op(1'b0, MD_DIVU, 64'd9, 64'd3, 5'd12, 64'd3, 33, 1'b0, "after_flush");

        // Flush together with an issue in IDLE drops the request
        @(negedge clk);
        iv32 = 1'b1; flush = 1'b1; op32 = MD_MUL; a32 = 32'd2; b32 = 32'd2; rdi32 = 5'd4;
        @(negedge clk);
        iv32 = 1'b0; flush = 1'b0;
        check("flush_issue dropped_ready", 64'(ir32), 64'd1);
        check("flush_issue dropped_busy", 64'(busy32), 64'd0);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        iv32 = 1'b1; op32 = MD_MUL; a32 = 32'd5; b32 = 32'd6; rdi32 = 5'd17;
        @(negedge clk);
        iv32 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_reset busy", 64'(busy32), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset busy", 64'(busy32), 64'd0);
        check("async_reset in_ready", 64'(ir32), 64'd1);
        check("async_reset out_valid", 64'(ov32), 64'd0);
        check("async_reset res", 64'(res32), 64'd0);
        check("async_reset rd_out", 64'(rdo32), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (ov32) seen = 1'b1;
        end
        check("async_reset no_out_valid", 64'(seen), 64'd0);
        run_op(1'b0, MD_MUL, 64'd5, 64'd6, 5'd18, 64'd30, 33, 1'b0, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
